// File: rtl/cpu_run_monitor.sv
// Supervises a CPU test run: holds the CPU in reset, then watches its PC and
// fetched instruction until it reaches the pass address, stalls, or times out.
module cpu_run_monitor #(
  parameter int               XLEN           = 32,
  parameter int               RESET_CYCLES   = 2,
  parameter int               TIMEOUT_CYCLES = 10,
  parameter int               STALL_CYCLES   = 4,
  parameter logic [XLEN-1:0]  PASS_ADDR      = XLEN'(32'h0000_0040),
  parameter int               CW             = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] pc_address,
  input  logic [XLEN-1:0] encoded_instruction,
  output logic            cpu_reset,
  output logic            running,
  output logic            done,
  output logic            pass,
  output logic            fail_timeout,
  output logic            fail_stall,
  output logic [CW-1:0]   cycle_count,
  output logic [CW-1:0]   instr_count,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RST_HOLD = 2'd1,
    RUN      = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [CW-1:0]   CNT_ONE     = CW'(1);
  localparam logic [CW-1:0]   CNT_MAX     = '1;
  localparam logic [CW-1:0]   STALL_LIM   = CW'(STALL_CYCLES);
  localparam logic [CW-1:0]   TIMEOUT_LIM = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      HOLD_LIM    = 8'(RESET_CYCLES);
  localparam logic [XLEN-1:0] EBREAK      = XLEN'(32'h0010_0073);

  state_t          state;
  logic [7:0]      hold_cnt;
  logic [CW-1:0]   stall_cnt;
  logic [XLEN-1:0] prev_pc;
  logic            first_cycle;

  logic            pc_changed;
  logic [CW-1:0]   stall_next;
  logic            hit_pass;
  logic            hit_stall;
  logic            hit_timeout;

  assign running   = (state == RUN);
  assign done      = (state == DONE);
  assign dbg_state = state;

  always_comb begin
    pc_changed = first_cycle || (pc_address != prev_pc);
    if (pc_changed)
      stall_next = CNT_ONE;
    else if (stall_cnt == CNT_MAX)
      stall_next = stall_cnt;
    else
      stall_next = stall_cnt + CNT_ONE;
    hit_pass    = (pc_address == PASS_ADDR);
    hit_stall   = (stall_next == STALL_LIM) || (encoded_instruction == EBREAK);
    hit_timeout = (cycle_count == TIMEOUT_LIM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cpu_reset    <= 1'b1;
      hold_cnt     <= '0;
      stall_cnt    <= '0;
      prev_pc      <= '0;
      first_cycle  <= 1'b0;
      pass         <= 1'b0;
      fail_timeout <= 1'b0;
      fail_stall   <= 1'b0;
      cycle_count  <= '0;
      instr_count  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= RST_HOLD;
            cpu_reset    <= 1'b1;
            hold_cnt     <= 8'd1;
            stall_cnt    <= '0;
            prev_pc      <= '0;
            first_cycle  <= 1'b0;
            pass         <= 1'b0;
            fail_timeout <= 1'b0;
            fail_stall   <= 1'b0;
            cycle_count  <= '0;
            instr_count  <= '0;
          end
        end
        RST_HOLD: begin
          if (hold_cnt == HOLD_LIM) begin
            state       <= RUN;
            cpu_reset   <= 1'b0;
            first_cycle <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        RUN: begin
          first_cycle <= 1'b0;
          prev_pc     <= pc_address;
          stall_cnt   <= stall_next;
          if (pc_changed && instr_count != CNT_MAX)
            instr_count <= instr_count + CNT_ONE;
          // On the detecting cycle cycle_count keeps the value it was compared at.
          if (hit_pass || hit_stall || hit_timeout) begin
            state        <= DONE;
            cpu_reset    <= 1'b1;
            pass         <= hit_pass;
            fail_stall   <= !hit_pass && hit_stall;
            fail_timeout <= !hit_pass && !hit_stall && hit_timeout;
          end else if (cycle_count != CNT_MAX) begin
            cycle_count <= cycle_count + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
